// File: rtl/if_id_skid_buffer_pkg.sv
// Shared fetch/decode pipeline types.
// Bundle layout, skid FSM states and the bubble instruction.
package if_id_skid_buffer_pkg;

  localparam int DATA_WIDTH = 32;

  localparam logic [DATA_WIDTH-1:0] NOP_INSTR =
    32'h0000_0013;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] instr;
    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] pc_plus4;
  } fetch_bundle_t;

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    FULL
  } skid_state_t;

endpackage

// File: rtl/if_id_skid_buffer.sv
// IF/ID receiver: 2-entry valid/ready skid buffer.
// Head drives decode directly; skid absorbs one bundle on stall.
module if_id_skid_buffer #(
  parameter int DATA_WIDTH =
    if_id_skid_buffer_pkg::DATA_WIDTH,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR =
    if_id_skid_buffer_pkg::NOP_INSTR
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [DATA_WIDTH-1:0] Instr_i,
  input  logic [DATA_WIDTH-1:0] PC_i,
  input  logic [DATA_WIDTH-1:0] PCPlus4_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [DATA_WIDTH-1:0] Instr_o,
  output logic [DATA_WIDTH-1:0] PC_o,
  output logic [DATA_WIDTH-1:0] PCPlus4_o
);

  import if_id_skid_buffer_pkg::*;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] instr;
    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] pc_plus4;
  } ifid_t;

  skid_state_t state_q;
  skid_state_t state_d;

  ifid_t head_q;
  ifid_t head_d;
  ifid_t skid_q;
  ifid_t skid_d;
  ifid_t in_b;
  ifid_t nop_b;

  logic push;
  logic pop;

  assign in_b = '{
    instr:    Instr_i,
    pc:       PC_i,
    pc_plus4: PCPlus4_i
  };

  assign nop_b = '{
    instr:    NOP_INSTR,
    pc:       '0,
    pc_plus4: '0
  };

  // ready_o is a flop, so ready_i never reaches it.
  assign push = valid_i & ready_o;
  assign pop  = valid_o & ready_i;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    if (flush_i) begin
      state_d = EMPTY;
      head_d  = nop_b;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (push) begin
            state_d = ONE;
            head_d  = in_b;
          end
        end
        ONE: begin
          unique case ({push, pop})
            2'b11: begin
              head_d = in_b;
            end
            2'b10: begin
              state_d = FULL;
              skid_d  = in_b;
            end
            2'b01: begin
              state_d = EMPTY;
              head_d  = nop_b;
            end
            default: begin
              state_d = ONE;
            end
          endcase
        end
        FULL: begin
          if (pop) begin
            state_d = ONE;
            head_d  = skid_q;
          end
        end
        default: begin
          state_d = EMPTY;
          head_d  = nop_b;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      head_q  <= nop_b;
      skid_q  <= '0;
      valid_o <= 1'b0;
      ready_o <= 1'b1;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      skid_q  <= skid_d;
      valid_o <= (state_d != EMPTY);
      ready_o <= (state_d != FULL);
    end
  end

  assign Instr_o   = head_q.instr;
  assign PC_o      = head_q.pc;
  assign PCPlus4_o = head_q.pc_plus4;

endmodule

// File: doc/if_id_skid_buffer.md
Name: if_id_skid_buffer

Overview:
- Decode-side receiver of the fetch→decode interface; replaces the bare enable-gated IF/ID register with a 2-entry valid/ready skid buffer.
- Fetch pushes {Instr, PC, PCPlus4} with a valid/ready handshake. Decode pops with its own ready.
- A decode stall therefore never combinationally gates fetch, and a branch/jump redirect can squash in-flight instructions by flushing.

Parameters:
- DATA_WIDTH, 32, width of Instr, PC and PCPlus4.
- NOP_INSTR, 32'h0000_0013, instruction presented on Instr_o when the buffer is empty or flushed (addi x0,x0,0).

Ports:
- clk  input  1  system clock; rising-edge active.
- rst  input  1  synchronous, active-high reset.
- flush_i  input  1  squash all buffered entries (branch taken / jump redirect).
- valid_i  input  1  fetch presents a valid instruction bundle.
- ready_o  output  1  buffer can accept a bundle this cycle.
- Instr_i  input  DATA_WIDTH  fetched instruction.
- PC_i  input  DATA_WIDTH  PC of fetched instruction.
- PCPlus4_i  input  DATA_WIDTH  PC+4 of fetched instruction.
- valid_o  output  1  Instr_o/PC_o/PCPlus4_o hold a valid bundle.
- ready_i  input  1  decode accepts the head bundle this cycle.
- Instr_o  output  DATA_WIDTH  head instruction.
- PC_o  output  DATA_WIDTH  head PC.
- PCPlus4_o  output  DATA_WIDTH  head PC+4.

Behaviour:
- Clocking and reset:
  - One clock, clk. All state updates on the rising edge.
  - Reset is synchronous and active-high on rst, and has top priority.
  - Reset values: state=EMPTY, valid_o=0, ready_o=1, Instr_o=NOP_INSTR, PC_o=0, PCPlus4_o=0, skid register=0.
- Handshake definitions:
  - push = valid_i & ready_o.
  - pop = valid_o & ready_i.
  - Fetch must hold valid_i and its data stable until ready_o is 1.
- Storage and outputs:
  - Head register drives the outputs directly, so outputs are registered.
  - One skid register sits behind the head.
  - ready_o = (state != FULL), registered and derived from state only; there is no combinational path from ready_i to ready_o.
- State machine (EMPTY, ONE, FULL):
  - EMPTY:
    - push → ONE, head <= input.
    - otherwise stay in EMPTY.
  - ONE:
    - push & pop → ONE, head <= input (back-to-back streaming).
    - push & !pop → FULL, skid <= input.
    - !push & pop → EMPTY, head <= {NOP_INSTR, 0, 0}.
    - otherwise hold.
  - FULL:
    - pop → ONE, head <= skid.
    - otherwise hold.
    - push is impossible because ready_o=0.
- Latency and throughput:
  - push to valid_o: 1 cycle.
  - Sustained throughput: 1 bundle/cycle while ready_i=1.
- Flush:
  - flush_i=1 → next state EMPTY, head <= {NOP_INSTR, 0, 0}, valid_o=0 next cycle.
  - Any push or pop in the same cycle is discarded; flush beats push.
  - The skid register content becomes don't-care.
- Ordering: bundles exit in strict push order, with no drop or duplication except on flush.
- Empty: valid_o=0 and outputs show NOP_INSTR/0/0, so decode sees a bubble.
- Full: ready_o=0 and head/skid are held indefinitely while ready_i=0.
- Reset mid-stream overrides flush_i, valid_i and ready_i.

Decomposition:
- Shared pipeline package holds:
  - typedef fetch_bundle_t (packed struct {instr, pc, pc_plus4}, each DATA_WIDTH).
  - typedef skid_state_t enum {EMPTY, ONE, FULL}.
  - constant NOP_INSTR.
- Single module; no sub-module is needed. A generic skid_buffer could be factored out later, but it is not required.

Test Plan:
- Reset: assert rst 2 cycles → valid_o=0, ready_o=1, Instr_o=32'h00000013, PC_o=0, PCPlus4_o=0.
- Streaming: ready_i=1; push PC 0x00,0x04,0x08 with Instr 0xA,0xB,0xC on consecutive cycles → valid_o high from cycle 1, outputs in order, 1 per cycle, ready_o stays 1.
- Stall fill: ready_i=0; push PC 0x10 then 0x14 → state FULL, ready_o=0 after 2nd push, Instr_o holds PC 0x10 bundle. Hold valid_i with PC 0x18 for 3 cycles → not accepted.
- Drain: from FULL set ready_i=1 → cycle 1 outputs PC 0x10, then PC 0x14 (ready_o returns 1), then PC 0x18 accepted. No loss or duplication.
- Flush with push: in state FULL, assert flush_i and valid_i (PC 0x20) together → next cycle valid_o=0, Instr_o=0x13, ready_o=1, PC 0x20 not emitted.
- Reset mid-operation: state ONE with valid_i=1, ready_i=0, rst=1 → next cycle reset values, buffered bundle lost.
